// File: rtl/rgb2ycbcr_pipe.sv
// Three-stage streaming RGB -> full-range YCbCr converter with run-time BT.601/BT.709
// selection latched on vs rising edges, plus per-line pixel and per-frame line counters.
module rgb2ycbcr_pipe #(
    parameter int COLORDEPTH = 8,
    parameter int CNTW       = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*COLORDEPTH-1:0] rgb_i,
    input  logic                    dv_i,
    input  logic                    hs_i,
    input  logic                    vs_i,
    input  logic                    mode_i,
    output logic [COLORDEPTH-1:0]   y_o,
    output logic [COLORDEPTH-1:0]   cb_o,
    output logic [COLORDEPTH-1:0]   cr_o,
    output logic                    dv_o,
    output logic                    hs_o,
    output logic                    vs_o,
    output logic                    line_end,
    output logic [CNTW-1:0]         px_cnt_o,
    output logic [CNTW-1:0]         line_cnt_o,
    output logic                    mode_o
);

    localparam int ACCW = COLORDEPTH + 11;
    localparam int CW   = 9;

    localparam logic signed [ACCW-1:0] RND  = {{(ACCW-8){1'b0}}, 8'h80};
    localparam logic signed [ACCW-1:0] OFS  = {{(ACCW-COLORDEPTH-8){1'b0}}, 1'b1, {(COLORDEPTH+7){1'b0}}};
    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-COLORDEPTH){1'b0}}, {COLORDEPTH{1'b1}}};

    // Coefficient order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B).
    localparam logic signed [CW-1:0] K601 [9] = '{9'sd77, 9'sd150, 9'sd29,
                                                  -9'sd43, -9'sd85, 9'sd128,
                                                  9'sd128, -9'sd107, -9'sd21};
    localparam logic signed [CW-1:0] K709 [9] = '{9'sd54, 9'sd183, 9'sd19,
                                                  -9'sd29, -9'sd99, 9'sd128,
                                                  9'sd128, -9'sd116, -9'sd12};

    function automatic logic signed [ACCW-1:0] mulc(input logic [COLORDEPTH-1:0] c,
                                                    input logic signed [CW-1:0] k);
        logic signed [ACCW-1:0] a;
        logic signed [ACCW-1:0] b;
        a = $signed({{(ACCW-COLORDEPTH){1'b0}}, c});
        b = {{(ACCW-CW){k[CW-1]}}, k};
        return a * b;
    endfunction

    function automatic logic [COLORDEPTH-1:0] clamp(input logic signed [ACCW-1:0] v);
        if (v[ACCW-1])
            return '0;
        else if (v > MAXV)
            return '1;
        else
            return v[COLORDEPTH-1:0];
    endfunction

    // S1: registered inputs; mode_s1_q doubles as the active coefficient set.
    logic [3*COLORDEPTH-1:0] rgb_s1_q;
    logic                    dv_s1_q, hs_s1_q, vs_s1_q, mode_s1_q, mode_s1_d;
    logic                    vs_rise;

    // S2: products
    logic signed [ACCW-1:0]  prod_q [9];
    logic signed [ACCW-1:0]  prod_d [9];
    logic [COLORDEPTH-1:0]   comp [3];
    logic                    dv_s2_q, hs_s2_q, vs_s2_q, mode_s2_q;

    // S3: outputs
    logic signed [ACCW-1:0]  sum_y, sum_cb, sum_cr;
    logic [COLORDEPTH-1:0]   y_q, cb_q, cr_q, y_d, cb_d, cr_d;
    logic                    dv_o_q, hs_o_q, vs_o_q, mode_o_q;
    logic                    line_end_q, line_end_d;
    logic [CNTW-1:0]         px_cnt_q, px_cnt_d, line_cnt_q, line_cnt_d;

    always_comb begin
        vs_rise   = vs_i & ~vs_s1_q;
        mode_s1_d = vs_rise ? mode_i : mode_s1_q;
    end

    always_comb begin
        comp[0] = rgb_s1_q[3*COLORDEPTH-1:2*COLORDEPTH];
        comp[1] = rgb_s1_q[2*COLORDEPTH-1:COLORDEPTH];
        comp[2] = rgb_s1_q[COLORDEPTH-1:0];
        for (int i = 0; i < 9; i++)
            prod_d[i] = mulc(comp[i % 3], mode_s1_q ? K709[i] : K601[i]);
    end

    always_comb begin
        sum_y  = prod_q[0] + prod_q[1] + prod_q[2] + RND;
        sum_cb = prod_q[3] + prod_q[4] + prod_q[5] + OFS + RND;
        sum_cr = prod_q[6] + prod_q[7] + prod_q[8] + OFS + RND;
        y_d    = dv_s2_q ? clamp(sum_y  >>> 8) : '0;
        cb_d   = dv_s2_q ? clamp(sum_cb >>> 8) : '0;
        cr_d   = dv_s2_q ? clamp(sum_cr >>> 8) : '0;
    end

    // Counters are computed from the stream entering the output register.
    always_comb begin
        line_end_d = dv_o_q & ~dv_s2_q;
        px_cnt_d   = px_cnt_q;
        if (dv_s2_q) begin
            if (!dv_o_q)
                px_cnt_d = '0;
            else if (px_cnt_q != '1)
                px_cnt_d = px_cnt_q + 1'b1;
        end
        line_cnt_d = line_cnt_q;
        if (vs_s2_q && !vs_o_q)
            line_cnt_d = '0;
        else if (line_end_d && line_cnt_q != '1)
            line_cnt_d = line_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_s1_q   <= '0;
            dv_s1_q    <= 1'b0;
            hs_s1_q    <= 1'b0;
            vs_s1_q    <= 1'b0;
            mode_s1_q  <= 1'b0;
            prod_q     <= '{default: '0};
            dv_s2_q    <= 1'b0;
            hs_s2_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            mode_s2_q  <= 1'b0;
            y_q        <= '0;
            cb_q       <= '0;
            cr_q       <= '0;
            dv_o_q     <= 1'b0;
            hs_o_q     <= 1'b0;
            vs_o_q     <= 1'b0;
            mode_o_q   <= 1'b0;
            line_end_q <= 1'b0;
            px_cnt_q   <= '0;
            line_cnt_q <= '0;
        end else begin
            rgb_s1_q   <= rgb_i;
            dv_s1_q    <= dv_i;
            hs_s1_q    <= hs_i;
            vs_s1_q    <= vs_i;
            mode_s1_q  <= mode_s1_d;
            prod_q     <= prod_d;
            dv_s2_q    <= dv_s1_q;
            hs_s2_q    <= hs_s1_q;
            vs_s2_q    <= vs_s1_q;
            mode_s2_q  <= mode_s1_q;
            y_q        <= y_d;
            cb_q       <= cb_d;
            cr_q       <= cr_d;
            dv_o_q     <= dv_s2_q;
            hs_o_q     <= hs_s2_q;
            vs_o_q     <= vs_s2_q;
            mode_o_q   <= mode_s2_q;
            line_end_q <= line_end_d;
            px_cnt_q   <= px_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    assign y_o        = y_q;
    assign cb_o       = cb_q;
    assign cr_o       = cr_q;
    assign dv_o       = dv_o_q;
    assign hs_o       = hs_o_q;
    assign vs_o       = vs_o_q;
    assign mode_o     = mode_o_q;
    assign line_end   = line_end_q;
    assign px_cnt_o   = px_cnt_q;
    assign line_cnt_o = line_cnt_q;

endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Bench for rgb2ycbcr_pipe: directed literal checks plus randomized traffic checked
// every cycle against a frame-level behavioural model.
module tb_rgb2ycbcr_pipe;
  localparam int CD = 8;
  localparam int CNTW = 12;
  localparam int CMAX = (1 << CNTW) - 1;

  // coefficient table: [mode*9 + channel*3 + component]
  localparam int KT [0:17] = '{77, 150, 29, -43, -85, 128, 128, -107, -21,
                               54, 183, 19, -29, -99, 128, 128, -116, -12};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3*CD-1:0] rgb_i = '0;
  logic dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0, mode_i = 1'b0;
  logic [CD-1:0] y_o, cb_o, cr_o;
  logic dv_o, hs_o, vs_o, line_end, mode_o;
  logic [CNTW-1:0] px_cnt_o, line_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  rgb2ycbcr_pipe #(.COLORDEPTH(CD), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .rgb_i(rgb_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .mode_i(mode_i), .y_o(y_o), .cb_o(cb_o), .cr_o(cr_o), .dv_o(dv_o), .hs_o(hs_o),
    .vs_o(vs_o), .line_end(line_end), .px_cnt_o(px_cnt_o), .line_cnt_o(line_cnt_o),
    .mode_o(mode_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  typedef struct {
    logic dv, hs, vs, md;
    int y, cb, cr;
  } rec_t;

  function automatic int conv(int r, int g, int b, int ch, logic md);
    int base, s, v;
    base = (md ? 9 : 0) + ch * 3;
    s = KT[base] * r + KT[base + 1] * g + KT[base + 2] * b;
    if (ch != 0) s = s + (1 << (CD - 1 + 8));
    v = (s + 128) >>> 8;
    if (v < 0) v = 0;
    if (v > (1 << CD) - 1) v = (1 << CD) - 1;
    return v;
  endfunction

  function automatic rec_t blank();
    rec_t b;
    b.dv = 0; b.hs = 0; b.vs = 0; b.md = 0; b.y = 0; b.cb = 0; b.cr = 0;
    return b;
  endfunction

  rec_t hist[$];
  rec_t m_out;
  logic m_act_mode = 0, m_prev_vs_in = 0, m_prev_dv = 0, m_prev_vs = 0, m_le = 0;
  int m_px = 0, m_ln = 0;

  initial begin
    hist.push_back(blank());
    hist.push_back(blank());
    m_out = blank();
  end

  always @(posedge clk) begin
    rec_t f;
    int r, g, b;
    if (rst) begin
      m_act_mode = 0; m_prev_vs_in = 0; m_prev_dv = 0; m_prev_vs = 0; m_le = 0;
      m_px = 0; m_ln = 0;
      hist.delete();
      hist.push_back(blank());
      hist.push_back(blank());
      m_out = blank();
    end else begin
      if (vs_i && !m_prev_vs_in) m_act_mode = mode_i;
      m_prev_vs_in = vs_i;
      r = int'(rgb_i[23:16]); g = int'(rgb_i[15:8]); b = int'(rgb_i[7:0]);
      f.dv = dv_i; f.hs = hs_i; f.vs = vs_i; f.md = m_act_mode;
      f.y  = dv_i ? conv(r, g, b, 0, m_act_mode) : 0;
      f.cb = dv_i ? conv(r, g, b, 1, m_act_mode) : 0;
      f.cr = dv_i ? conv(r, g, b, 2, m_act_mode) : 0;
      m_out = hist.pop_front();
      hist.push_back(f);
      m_le = m_prev_dv && !m_out.dv;
      if (m_out.dv) m_px = m_prev_dv ? ((m_px < CMAX) ? m_px + 1 : CMAX) : 0;
      if (m_out.vs && !m_prev_vs) m_ln = 0;
      else if (m_le && m_ln < CMAX) m_ln = m_ln + 1;
      m_prev_dv = m_out.dv;
      m_prev_vs = m_out.vs;
    end
    #1;
    chk("y", 32'(y_o), 32'(m_out.y));
    chk("cb", 32'(cb_o), 32'(m_out.cb));
    chk("cr", 32'(cr_o), 32'(m_out.cr));
    chk("dv", 32'(dv_o), 32'(m_out.dv));
    chk("hs", 32'(hs_o), 32'(m_out.hs));
    chk("vs", 32'(vs_o), 32'(m_out.vs));
    chk("mode", 32'(mode_o), 32'(m_out.md));
    chk("line_end", 32'(line_end), 32'(m_le));
    chk("px_cnt", 32'(px_cnt_o), 32'(m_px));
    chk("line_cnt", 32'(line_cnt_o), 32'(m_ln));
  end

  // driver tasks: each call occupies one clock cycle
  task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic dv, input logic hs, input logic vs, input logic md);
    @(negedge clk);
    rgb_i = {r, g, b};
    dv_i = dv; hs_i = hs; vs_i = vs; mode_i = md;
  endtask

  function automatic logic [7:0] rnd_comp();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 8'd0;
    if (sel == 1) return 8'd255;
    return 8'($urandom);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic px_check(input string name, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input logic vs, input logic md,
                          input int ey, input int ecb, input int ecr, input logic em);
    drive(r, g, b, 1, 0, vs, md);
    drive(0, 0, 0, 0, 0, vs, md);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk({name, "_y"}, 32'(y_o), 32'(ey));
    chk({name, "_cb"}, 32'(cb_o), 32'(ecb));
    chk({name, "_cr"}, 32'(cr_o), 32'(ecr));
    chk({name, "_mode"}, 32'(mode_o), 32'(em));
    chk({name, "_dv"}, 32'(dv_o), 32'd1);
  endtask

  initial begin
    logic hs_r, vs_r;
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", 32'(y_o), 0);
    chk("rst_dv", 32'(dv_o), 0);
    chk("rst_mode", 32'(mode_o), 0);
    chk("rst_line_cnt", 32'(line_cnt_o), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // directed pixels
    px_check("white601", 255, 255, 255, 0, 0, 255, 128, 128, 0);
    px_check("red601", 255, 0, 0, 0, 0, 77, 85, 255, 0);
    px_check("blue_ignore", 0, 0, 255, 0, 1, 29, 255, 107, 0);
    px_check("blue709", 0, 0, 255, 1, 1, 19, 255, 116, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    px_check("red709", 255, 0, 0, 0, 0, 54, 99, 255, 1);
    idle(6);

    // 640-pixel line in a fresh BT.601 frame
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(5);
    for (int i = 0; i < 640; i++) drive(rnd_comp(), rnd_comp(), rnd_comp(), 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("le_e0", 32'(line_end), 0);
    @(posedge clk); #1;
    chk("le_e1", 32'(line_end), 0);
    chk("px_last", 32'(px_cnt_o), 639);
    @(posedge clk); #1;
    chk("le_e2", 32'(line_end), 1);
    chk("px_hold2", 32'(px_cnt_o), 639);
    chk("line_inc", 32'(line_cnt_o), 1);
    @(posedge clk); #1;
    chk("le_e3", 32'(line_end), 0);
    chk("px_hold3", 32'(px_cnt_o), 639);
    chk("line_hold", 32'(line_cnt_o), 1);
    idle(4);

    // random traffic with independent hs/vs
    hs_r = 0; vs_r = 0;
    for (int l = 0; l < 40; l++) begin
      int run, gap;
      run = $urandom_range(1, 80);
      gap = $urandom_range(0, 6);
      for (int i = 0; i < run + gap; i++) begin
        if ($urandom_range(0, 9) == 0) hs_r = ~hs_r;
        if ($urandom_range(0, 39) == 0) vs_r = ~vs_r;
        drive(rnd_comp(), rnd_comp(), rnd_comp(), (i < run), hs_r, vs_r,
              1'($urandom_range(0, 1)));
      end
    end
    idle(4);

    // pixel counter saturation
    for (int i = 0; i < 4100; i++) drive(rnd_comp(), rnd_comp(), rnd_comp(), 1, 0, 0, 0);
    idle(4);
    // line counter saturation
    for (int i = 0; i < 4100; i++) begin
      drive(rnd_comp(), rnd_comp(), rnd_comp(), 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
    end
    idle(4);
    chk("line_sat", 32'(line_cnt_o), CMAX);

    // reset mid-line with BT.709 active
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(rnd_comp(), rnd_comp(), rnd_comp(), 1, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_y", 32'(y_o), 0);
    chk("mrst_cb", 32'(cb_o), 0);
    chk("mrst_cr", 32'(cr_o), 0);
    chk("mrst_dv", 32'(dv_o), 0);
    chk("mrst_hs", 32'(hs_o), 0);
    chk("mrst_mode", 32'(mode_o), 0);
    chk("mrst_px", 32'(px_cnt_o), 0);
    chk("mrst_le", 32'(line_end), 0);
    @(negedge clk);
    rst = 1'b0;
    rgb_i = '0; dv_i = 0; hs_i = 0; vs_i = 0; mode_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_le", 32'(line_end), 0);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    px_check("post_rst_white", 255, 255, 255, 0, 0, 255, 128, 128, 0);
    px_check("post_rst_red", 255, 0, 0, 0, 1, 77, 85, 255, 0);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rgb2ycbcr_pipe.md
Name: rgb2ycbcr_pipe

Overview:
- Parametrised successor to the team's single-channel luma converter.
- Converts a streaming RGB pixel bus to full-range Y, Cb and Cr with rounding and saturation.
- Coefficient set (BT.601 or BT.709) is selected at run time, switched only at frame boundaries.
- Sits between the video input sync stage and downstream grayscale/chroma processing. Also supplies per-line pixel and per-frame line counters.

Parameters:
- COLORDEPTH, 8, bits per colour component; applies to both input and output components.
- CNTW, 12, width of the pixel and line counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rgb_i  in  3*COLORDEPTH  {R,G,B}; R in the MSBs.
- dv_i  in  1  data valid.
- hs_i  in  1  horizontal sync.
- vs_i  in  1  vertical sync.
- mode_i  in  1  coefficient set request: 0 = BT.601, 1 = BT.709.
- y_o  out  COLORDEPTH  luma.
- cb_o  out  COLORDEPTH  blue-difference chroma.
- cr_o  out  COLORDEPTH  red-difference chroma.
- dv_o  out  1  data valid, delayed.
- hs_o  out  1  horizontal sync, delayed.
- vs_o  out  1  vertical sync, delayed.
- line_end  out  1  one-cycle pulse after the last valid pixel of a line.
- px_cnt_o  out  CNTW  index of the current output pixel within its line.
- line_cnt_o  out  CNTW  index of the current line within the frame.
- mode_o  out  1  coefficient set currently in effect.

Behaviour:
- Reset: all outputs 0, all pipeline registers 0, active mode = 0 (BT.601). Reset mid-line discards in-flight pixels; no line_end is generated for the aborted line.
- Latency: fixed 3 cycles from inputs to every output.
  - S1 registers inputs and detects vs rising edge.
  - S2 forms the nine products.
  - S3 sums, rounds, clamps and registers.
  - dv, hs and vs are delayed exactly 3 cycles; hs_o follows hs_i, never vs.
- Mode latch: mode_i is sampled only in the cycle S1 detects a vs_i rising edge (vs_i=1 while the previous vs_i=0).
  - The new mode applies starting with that pixel and to every following pixel.
  - mode_i changes at any other time are ignored.
  - mode_o shows the mode applied to the pixel currently on the outputs.
- Arithmetic: coefficients are signed 8-fraction-bit fixed point. Let O = 2^(COLORDEPTH-1) << 8.
  - BT.601: Y = 77R + 150G + 29B; Cb = -43R - 85G + 128B + O; Cr = 128R - 107G - 21B + O.
  - BT.709: Y = 54R + 183G + 19B; Cb = -29R - 99G + 128B + O; Cr = 128R - 116G - 12B + O.
  - Accumulators are signed, COLORDEPTH+11 bits.
  - Result = (sum + 128) >>> 8 (arithmetic shift), then clamped to [0, 2^COLORDEPTH-1].
- Blanking: when the delayed dv is 0, y_o, cb_o and cr_o are 0.
- line_end: asserted for one cycle when dv_o transitions 1 to 0, i.e. in the first cycle with dv_o=0 after dv_o=1.
- px_cnt_o:
  - 0 on the first valid pixel of a line; increments on each subsequent dv_o=1 cycle.
  - Saturates at 2^CNTW-1.
  - Holds its value while dv_o=0; re-zeroes on the next line's first valid pixel.
- line_cnt_o:
  - Cleared when vs_o rises.
  - Increments in the cycle line_end pulses; saturates at 2^CNTW-1.
  - If vs_o rises in the same cycle as line_end, the clear wins.

Test Plan:
- Reset, then white (255,255,255) with dv=1, mode 0 -> 3 cycles later y=255, cb=128, cr=128.
- Red (255,0,0), BT.601 -> y=77, cb=85, cr=255 (the Cr result 256 is clamped to 255).
- Blue (0,0,255) -> y=19, cb=255, cr=116.
  - Drive mode_i=1 mid-frame: no change.
  - Then a vs rising edge with mode_i=1: the BT.709 results above appear from that pixel onward, and mode_o=1.
- Line of 640 valid pixels then dv=0 -> px_cnt_o reaches 639 and holds; line_end pulses exactly once, 3 cycles after dv_i falls; line_cnt_o increments by 1.
- Independent hs_i and vs_i patterns -> hs_o and vs_o are each exact 3-cycle copies; y/cb/cr=0 whenever dv_o=0.
- Assert rst for 1 cycle mid-line -> the next cycle shows all outputs 0 and mode_o=0, with no line_end pulse; the next frame processes normally.
